ifstage_fetch: RTL and testbench
================================

IFSTAGE_FETCH -- requirements
Module: ifstage_fetch

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, 16, number of REQ-state cycles without IMem_Ack before Fetch_Err sets (range 2..255).
REQ-002 The block SHALL have port Clk, input, 1, single clock; all state changes on rising edge.
REQ-003 The block SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port PC_Sel, input, 1, next-PC select: 0 = PC+4, 1 = branch target.
REQ-005 The block SHALL have port PC_LdEn, input, 1, advance request from control; consumes the current instruction.
REQ-006 The block SHALL have port Imm, input, 32, sign-extended branch offset in words.
REQ-007 The block SHALL have port IMem_Data, input, 32, instruction word returned by the instruction memory.
REQ-008 The block SHALL have port IMem_Ack, input, 1, memory data valid, one-cycle pulse.
REQ-009 The block SHALL have port IMem_Req, output, 1, fetch request to the instruction memory.
REQ-010 The block SHALL have port IMem_Addr, output, 32, fetch byte address.
REQ-011 The block SHALL have port Instr, output, 32, registered instruction presented to control.
REQ-012 The block SHALL have port Instr_Valid, output, 1, Instr holds a fetched word not yet consumed.
REQ-013 The block SHALL have port PC, output, 32, address of Instr / current fetch.
REQ-014 The block SHALL have port Fetch_Err, output, 1, sticky memory-timeout flag.

Function
REQ-015 The FSM SHALL have states IDLE, REQ and HOLD; IDLE is entered only by reset.
REQ-016 From IDLE, the FSM SHALL go unconditionally to REQ on the first clock edge after Reset deasserts.
REQ-017 In REQ, IMem_Req SHALL be 1 and IMem_Addr SHALL equal PC, both stable until IMem_Ack.
REQ-018 On IMem_Ack in REQ, the block SHALL register IMem_Data into Instr, set Instr_Valid=1, clear IMem_Req and go to HOLD on the same edge; Fetch time is 1 cycle after the Ack edge.
REQ-019 In HOLD, Instr and PC SHALL remain stable while PC_LdEn=0.
REQ-020 In HOLD with PC_LdEn=1, the block SHALL load PC with PC+4 (PC_Sel=0) or PC+4+(Imm<<2) (PC_Sel=1), clear Instr_Valid and go to REQ.
REQ-021 All PC arithmetic SHALL be modulo 2^32; overflow wraps silently (0xFFFFFFFC+4 = 0x00000000).
REQ-022 PC[1:0] SHALL always be 00; Imm bits [31:30] are discarded by the shift.
REQ-023 PC_LdEn and PC_Sel SHALL be ignored in IDLE and REQ.
REQ-024 IMem_Ack SHALL be ignored in IDLE and HOLD.
REQ-025 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without Ack, saturating at TIMEOUT.
REQ-026 When the counter reaches TIMEOUT, Fetch_Err SHALL set to 1 and stay 1 until reset; the FSM SHALL remain in REQ, keep requesting, and accept a late Ack normally.
REQ-027 When Ack and the timeout occur in the same cycle, the Ack SHALL be taken and Fetch_Err SHALL NOT set.
REQ-028 Instr SHALL retain its last value while Instr_Valid=0.

Reset
REQ-029 Asserting Reset=0 at any time, including mid-REQ, SHALL immediately force state=IDLE, PC=0, IMem_Addr=0, IMem_Req=0, Instr=0, Instr_Valid=0, Fetch_Err=0 and clear the wait counter.
REQ-030 An IMem_Ack arriving during or after reset, belonging to an aborted request, SHALL be ignored unless the FSM is in REQ.

Verification
REQ-031 Release reset, memory acks 2 cycles after Req with 0x8000_0001 -> IMem_Addr=0, Req high 2 cycles, then Instr=0x80000001, Instr_Valid=1, PC=0.
REQ-032 In HOLD at PC=0x10, PC_LdEn=1, PC_Sel=0 -> PC=0x14, Instr_Valid=0, IMem_Req=1, IMem_Addr=0x14 next cycle.
REQ-033 In HOLD at PC=0x10, PC_Sel=1, Imm=0xFFFFFFFE -> PC=0x0C; with Imm=3 -> PC=0x20.
REQ-034 TIMEOUT=16, no Ack -> Fetch_Err=1 after 16 REQ cycles; Ack on cycle 20 -> Instr loaded, Fetch_Err stays 1; Ack exactly on cycle 16 -> Fetch_Err stays 0.
REQ-035 Reset pulsed low in REQ with Ack on the next cycle -> all outputs at reset values, Ack ignored, fetch restarts at 0.
REQ-036 PC=0xFFFFFFFC, PC_LdEn=1, PC_Sel=0 -> PC=0x00000000; PC_LdEn pulsed during REQ -> PC unchanged.

Source files
------------

// File: rtl/ifstage_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifstage_fetch
//  Description : Instruction-fetch stage. Holds the program counter, issues
//                one outstanding request at a time to the instruction memory,
//                registers the returned word for the control unit, and flags
//                a sticky error when the memory is slow to acknowledge.
//
//  Ports
//    Clk          in   1   single clock, rising edge
//    Reset        in   1   asynchronous, active-low
//    PC_Sel       in   1   next-PC select: 0 = PC+4, 1 = branch target
//    PC_LdEn      in   1   consume current instruction and advance the PC
//    Imm          in  32   sign-extended branch offset, in words
//    IMem_Data    in  32   instruction word from memory
//    IMem_Ack     in   1   memory data valid (single-cycle pulse)
//    IMem_Req     out  1   fetch request to memory
//    IMem_Addr    out 32   fetch byte address
//    Instr        out 32   registered instruction for control
//    Instr_Valid  out  1   Instr holds a fetched word not yet consumed
//    PC           out 32   address of Instr / current fetch
//    Fetch_Err    out  1   sticky memory-timeout flag
//
//  Parameters
//    TIMEOUT      REQ cycles without IMem_Ack before Fetch_Err sets (2..255)
//
//  Revision    : 1.0  initial release
// ============================================================================
module ifstage_fetch #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PC_Sel,
    input  logic        PC_LdEn,
    input  logic [31:0] Imm,
    input  logic [31:0] IMem_Data,
    input  logic        IMem_Ack,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic [31:0] PC,
    output logic        Fetch_Err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // The wait counter is 8 bits wide, enough for the largest TIMEOUT.
    localparam logic [7:0]  C_TIMEOUT    = 8'(TIMEOUT);
    localparam logic [7:0]  C_TIMEOUT_M1 = 8'(TIMEOUT - 1);
    localparam logic [31:0] C_PC_STEP    = 32'd4;

    // ------------------------------------------------------------------
    // State encoding. IDLE is only reachable through reset.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic        r_instr_valid;
    logic        w_instr_valid_nxt;
    logic        r_fetch_err;
    logic        w_fetch_err_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;

    // Candidate next-PC values. Every operand is a multiple of four, so the
    // two low PC bits stay zero for ever; Imm bits [31:30] fall off the top
    // of the shift and the sums wrap modulo 2^32.
    logic [31:0] w_pc_seq;
    logic [31:0] w_pc_branch;

    assign w_pc_seq    = r_pc + C_PC_STEP;
    assign w_pc_branch = w_pc_seq + (Imm << 2);

    // ------------------------------------------------------------------
    // Sequential process: every piece of state, async active-low reset.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_fetch_err   <= w_fetch_err_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Combinational process: next state and datapath updates.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_valid_nxt = r_instr_valid;
        w_fetch_err_nxt   = r_fetch_err;
        w_wait_cnt_nxt    = r_wait_cnt;

        case (r_state)
            S_IDLE: begin
                // Leave IDLE unconditionally; anything arriving on the
                // memory interface now belongs to an aborted request.
                w_state_nxt    = S_REQ;
                w_wait_cnt_nxt = '0;
            end

            S_REQ: begin
                if (IMem_Ack) begin
                    // An Ack takes priority over a timeout in the same cycle,
                    // so the error flag is left untouched here.
                    w_instr_nxt       = IMem_Data;
                    w_instr_valid_nxt = 1'b1;
                    w_state_nxt       = S_HOLD;
                end else begin
                    if (r_wait_cnt != C_TIMEOUT) begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                    // The counter reaches TIMEOUT on this edge (or already
                    // has); the request stays up and a late Ack is accepted.
                    if (r_wait_cnt >= C_TIMEOUT_M1) begin
                        w_fetch_err_nxt = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (PC_LdEn) begin
                    w_pc_nxt          = PC_Sel ? w_pc_branch : w_pc_seq;
                    w_instr_valid_nxt = 1'b0;
                    w_wait_cnt_nxt    = '0;
                    w_state_nxt       = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. The request is a decode of the registered state, so it
    // drops on the same edge that captures the Ack.
    // ------------------------------------------------------------------
    assign IMem_Req    = (r_state == S_REQ);
    assign IMem_Addr   = r_pc;
    assign PC          = r_pc;
    assign Instr       = r_instr;
    assign Instr_Valid = r_instr_valid;
    assign Fetch_Err   = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_ifstage_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifstage_fetch
//  Description : Self-checking bench for ifstage_fetch. Directed stimulus
//                pushes expected request addresses and fetched words into
//                queues; a monitor pops and compares them when the DUT raises
//                IMem_Req or Instr_Valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifstage_fetch;

    logic        Clk;
    logic        Reset;
    logic        PC_Sel;
    logic        PC_LdEn;
    logic [31:0] Imm;
    logic [31:0] IMem_Data;
    logic        IMem_Ack;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic [31:0] PC;
    logic        Fetch_Err;

    ifstage_fetch #(.TIMEOUT(16)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .PC_Sel      (PC_Sel),
        .PC_LdEn     (PC_LdEn),
        .Imm         (Imm),
        .IMem_Data   (IMem_Data),
        .IMem_Ack    (IMem_Ack),
        .IMem_Req    (IMem_Req),
        .IMem_Addr   (IMem_Addr),
        .Instr       (Instr),
        .Instr_Valid (Instr_Valid),
        .PC          (PC),
        .Fetch_Err   (Fetch_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } fetch_t;

    fetch_t      q_fetch[$];
    logic [31:0] q_addr[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic        r_prev_req   = 1'b0;
    logic        r_prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got event expected none", name);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_req(input logic [31:0] addr);
        q_addr.push_back(addr);
    endtask

    task automatic expect_fetch(input logic [31:0] instr, input logic [31:0] pc, input logic err);
        fetch_t f;
        f.instr = instr;
        f.pc    = pc;
        f.err   = err;
        q_fetch.push_back(f);
    endtask

    // Wait for the request, then acknowledge it in REQ cycle n.
    task automatic serve(input int n, input logic [31:0] d);
        int g = 0;
        while (!IMem_Req && g < 50) begin
            tick();
            g++;
        end
        if (!IMem_Req) fail_now("req_wait_timeout");
        repeat (n - 1) tick();
        IMem_Ack  = 1'b1;
        IMem_Data = d;
        tick();
        IMem_Ack  = 1'b0;
        IMem_Data = 32'h0;
    endtask

    task automatic fetch(input int n, input logic [31:0] d, input logic [31:0] pc, input logic err);
        expect_fetch(d, pc, err);
        serve(n, d);
        chk("req_low_after_ack", {31'd0, IMem_Req}, 32'd0);
    endtask

    task automatic advance(input logic sel, input logic [31:0] imm, input logic [31:0] new_pc);
        expect_req(new_pc);
        PC_Sel  = sel;
        Imm     = imm;
        PC_LdEn = 1'b1;
        tick();
        PC_LdEn = 1'b0;
        PC_Sel  = 1'b0;
        chk("pc_after_advance", PC, new_pc);
        chk("valid_cleared", {31'd0, Instr_Valid}, 32'd0);
    endtask

    // Monitor: compares on a rising IMem_Req and on a rising Instr_Valid.
    always @(negedge Clk) begin
        if (IMem_Req && !r_prev_req) begin
            if (q_addr.size() == 0) fail_now("unexpected_request");
            else chk("req_addr", IMem_Addr, q_addr.pop_front());
        end
        if (Instr_Valid && !r_prev_valid) begin
            if (q_fetch.size() == 0) fail_now("unexpected_instr");
            else begin
                fetch_t f;
                f = q_fetch.pop_front();
                chk("instr", Instr, f.instr);
                chk("instr_pc", PC, f.pc);
                chk("instr_err", {31'd0, Fetch_Err}, {31'd0, f.err});
            end
        end
        r_prev_req   <= IMem_Req;
        r_prev_valid <= Instr_Valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0; PC_Sel = 1'b0; PC_LdEn = 1'b0;
        Imm = 32'h0; IMem_Data = 32'h0; IMem_Ack = 1'b0;
        tick(); tick();
        chk("rst_pc", PC, 32'h0);
        chk("rst_addr", IMem_Addr, 32'h0);
        chk("rst_req", {31'd0, IMem_Req}, 32'd0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("rst_err", {31'd0, Fetch_Err}, 32'd0);

        // First fetch: Ack in second REQ cycle.
        expect_req(32'h0);
        Reset = 1'b1;
        fetch(2, 32'h8000_0001, 32'h0, 1'b0);

        advance(1'b0, 32'h0, 32'h4);  fetch(1, 32'h1000_0004, 32'h4, 1'b0);
        advance(1'b0, 32'h0, 32'h8);  fetch(3, 32'h1000_0008, 32'h8, 1'b0);
        advance(1'b0, 32'h0, 32'hC);  fetch(1, 32'h1000_000C, 32'hC, 1'b0);
        advance(1'b0, 32'h0, 32'h10); fetch(2, 32'h1000_0010, 32'h10, 1'b0);

        // HOLD must ignore a stray Ack and keep Instr/PC.
        IMem_Ack = 1'b1; IMem_Data = 32'hBAD0_BAD0;
        tick();
        IMem_Ack = 1'b0;
        tick();
        chk("hold_instr", Instr, 32'h1000_0010);
        chk("hold_pc", PC, 32'h10);
        chk("hold_valid", {31'd0, Instr_Valid}, 32'd1);

        // Branch backwards, then sequential.
        advance(1'b1, 32'hFFFF_FFFE, 32'h0C); fetch(1, 32'h2000_000C, 32'h0C, 1'b0);
        advance(1'b0, 32'h0, 32'h10);         fetch(1, 32'h2000_0010, 32'h10, 1'b0);
        advance(1'b0, 32'h0, 32'h14);
        chk("adv_req", {31'd0, IMem_Req}, 32'd1);
        chk("adv_addr", IMem_Addr, 32'h14);
        fetch(1, 32'h2000_0014, 32'h14, 1'b0);
        advance(1'b1, 32'hFFFF_FFFE, 32'h10); fetch(1, 32'h3000_0010, 32'h10, 1'b0);
        advance(1'b1, 32'h0000_0003, 32'h20); fetch(1, 32'h3000_0020, 32'h20, 1'b0);

        // Imm[31:30] drop out of the shift: 0x20+4+0xC = 0x30.
        advance(1'b1, 32'h4000_0003, 32'h30);
        // PC_LdEn during REQ is ignored.
        PC_LdEn = 1'b1; PC_Sel = 1'b1; Imm = 32'h5;
        tick();
        PC_LdEn = 1'b0; PC_Sel = 1'b0;
        chk("req_ignores_ld_pc", PC, 32'h30);
        chk("req_ignores_ld_req", {31'd0, IMem_Req}, 32'd1);
        fetch(1, 32'h3000_0030, 32'h30, 1'b0);

        // Ack exactly on REQ cycle 16: no error.
        advance(1'b0, 32'h0, 32'h34);
        fetch(16, 32'h3000_0034, 32'h34, 1'b0);
        chk("ack16_err", {31'd0, Fetch_Err}, 32'd0);

        // No Ack: error after 16 REQ cycles, late Ack on cycle 20 accepted.
        advance(1'b0, 32'h0, 32'h38);
        repeat (15) tick();
        chk("to_cycle16_err", {31'd0, Fetch_Err}, 32'd0);
        tick();
        chk("to_cycle17_err", {31'd0, Fetch_Err}, 32'd1);
        chk("to_still_req", {31'd0, IMem_Req}, 32'd1);
        repeat (3) tick();
        expect_fetch(32'h3000_0038, 32'h38, 1'b1);
        IMem_Ack = 1'b1; IMem_Data = 32'h3000_0038;
        tick();
        IMem_Ack = 1'b0;
        chk("late_ack_valid", {31'd0, Instr_Valid}, 32'd1);
        chk("late_ack_err", {31'd0, Fetch_Err}, 32'd1);

        // 0x3C + (-16<<2) = 0xFFFFFFFC, then wrap to 0.
        advance(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFC); fetch(1, 32'h4000_FFFC, 32'hFFFF_FFFC, 1'b1);
        advance(1'b0, 32'h0, 32'h0);                 fetch(1, 32'h4000_0000, 32'h0, 1'b1);

        // Reset mid-REQ, Ack on the following cycle is ignored.
        advance(1'b0, 32'h0, 32'h4);
        tick();
        Reset = 1'b0;
        #1;
        chk("mid_rst_pc", PC, 32'h0);
        chk("mid_rst_addr", IMem_Addr, 32'h0);
        chk("mid_rst_req", {31'd0, IMem_Req}, 32'd0);
        chk("mid_rst_instr", Instr, 32'h0);
        chk("mid_rst_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("mid_rst_err", {31'd0, Fetch_Err}, 32'd0);
        tick();
        expect_req(32'h0);
        Reset = 1'b1; IMem_Ack = 1'b1; IMem_Data = 32'hDEAD_BEEF;
        tick();
        IMem_Ack = 1'b0;
        chk("post_rst_instr", Instr, 32'h0);
        chk("post_rst_valid", {31'd0, Instr_Valid}, 32'd0);
        chk("post_rst_req", {31'd0, IMem_Req}, 32'd1);
        fetch(1, 32'h1234_5678, 32'h0, 1'b0);

        tick(); tick();
        chk("addr_queue_empty", q_addr.size(), 32'd0);
        chk("fetch_queue_empty", q_fetch.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
